if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage directly upstream of the IF/ID pipeline register: owns the PC,
//  fetches from the instruction ROM over a req/gnt/rvalid handshake, and holds fetched
//  {pc,inst} pairs in a small prefetch buffer that feeds if_pc/if_inst into IF/ID.
//  Honours downstream stall and redirects to a branch target, squashing stale fetches.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC of first fetch after reset (bits [1:0] must be 0)
//  BUF_DEPTH  2              prefetch buffer entries (power of 2, >=2)
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   asynchronous reset, active-low
//  stall_i          in   1   1 = IF/ID holds; head entry not consumed
//  branch_flag_i    in   1   redirect fetch this cycle
//  branch_target_i  in   32  redirect PC; bits [1:0] ignored (forced 00)
//  rom_req_o        out  1   fetch request
//  rom_addr_o       out  32  fetch address (word aligned)
//  rom_gnt_i        in   1   request accepted this cycle (when rom_req_o=1)
//  rom_rvalid_i     in   1   read data valid; >=1 cycle after gnt, in order
//  rom_rdata_i      in   32  instruction word
//  if_pc            out  32  PC of head entry
//  if_inst          out  32  instruction of head entry
//  if_valid         out  1   head entry present
// BEHAVIOUR
//  Reset (rst=0, async): fetch_pc=RESET_PC, buffer empty, state=IDLE, drop=0,
//   rom_req_o=0, rom_addr_o=0, if_valid=0, if_pc=0, if_inst=0.
//  if_pc/if_inst driven from buffer head; forced to 0 when buffer empty.
//  Consume: if_valid & ~stall_i pops head at clock edge.
//  At most 1 outstanding request. Issue allowed when count+outstanding < BUF_DEPTH.
//  FSM: IDLE -> REQ when issue allowed and no branch.
//       REQ: rom_req_o=1, rom_addr_o=fetch_pc. On gnt: fetch_pc+=4 (wraps mod 2^32),
//            -> WAIT. Without gnt, req/addr held stable (except on branch, below).
//       WAIT: on rvalid: push {issued_pc,rdata} unless drop; clear drop;
//            -> REQ if issue still allowed after push/pop, else IDLE.
//  Buffer push on rvalid and pop on consume may occur in the same cycle; count unchanged.
//   Full buffer never receives rvalid (guaranteed by issue rule).
//  Fetch latency: req asserted cycle N, gnt N, rvalid N+1 -> if_valid=1 in cycle N+2.
//  Branch (branch_flag_i=1), takes priority over all other updates that cycle:
//   - buffer cleared (entry popped that same cycle counts as delivered);
//   - fetch_pc <= {branch_target_i[31:2],2'b00};
//   - if a request is outstanding (WAIT, or REQ with gnt this cycle): drop<=1, its
//     rvalid is discarded, next request issued after it returns;
//   - if in REQ without gnt: request retargeted, addr = target next cycle (ROM must
//     tolerate address change while ungranted);
//   - if rvalid arrives in branch cycle: data discarded.
//  Back-to-back branches: latest target wins; drop stays set until one rvalid seen.
//  Mid-operation reset: all state cleared asynchronously; in-flight ROM response after
//   reset release is ignored only if it lands while state=IDLE/REQ (ROM reset with core).
// TESTING
//  1 Reset release, ROM gnt same cycle, rvalid +1, stall=0 -> if_pc=0,4,8,... one per
//    cycle sustained after pipeline fill? no: 1 per 2 cycles (1 outstanding); insts match ROM.
//  2 stall_i=1 for 6 cycles -> buffer fills to 2 (pc 0,4), rom_req_o=0, if_pc stays 0;
//    release -> 0,4,8 delivered in order, none lost/duplicated.
//  3 Branch to 0x100 while WAIT for pc 0x8 -> 0x8 response dropped, next if_pc=0x100.
//  4 Branch to 0x203 with gnt withheld -> rom_addr_o=0x200 next cycle, first if_pc=0x200.
//  5 Branch and rvalid same cycle; then branch again next cycle to 0x40 -> only 0x40 seen.
//  6 Fetch at 0xFFFF_FFFC -> next rom_addr_o=0x0; async reset mid-WAIT -> outputs 0 at once.

Source files
------------

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : Instruction-fetch stage with PC, ROM req/gnt/rvalid handshake and
//            a small prefetch buffer feeding IF/ID; handles stall and redirect.
// Revision : 1.0
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_gnt_i,
    input  logic        rom_rvalid_i,
    input  logic [31:0] rom_rdata_i,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             state;
    logic [31:0]        fetch_pc;
    logic [31:0]        issued_pc;
    logic               drop;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [63:0]        buf_mem [BUF_DEPTH];

    logic [31:0]        target;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   count_after;
    logic               issue_ok;
    logic [63:0]        head;

    assign target      = branch_target_i & ~32'h3;
    assign head        = buf_mem[rd_ptr];
    assign if_valid    = (count != '0);
    assign if_pc       = if_valid ? head[63:32] : 32'h0;
    assign if_inst     = if_valid ? head[31:0]  : 32'h0;
    assign pop         = if_valid & ~stall_i;
    assign push        = (state == S_WAIT) & rom_rvalid_i & ~drop & ~branch_flag_i;
    assign count_after = count + CNT_W'(push) - CNT_W'(pop);
    // Evaluated only when nothing is outstanding, so the buffer occupancy alone decides.
    assign issue_ok    = (count_after < CNT_W'(BUF_DEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr] <= {issued_pc, rom_rdata_i};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            fetch_pc   <= RESET_PC & ~32'h3;
            issued_pc  <= 32'h0;
            drop       <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            rom_req_o  <= 1'b0;
            rom_addr_o <= 32'h0;
        end else if (branch_flag_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= target;
            case (state)
                S_REQ: begin
                    if (rom_gnt_i) begin
                        drop       <= 1'b1;
                        issued_pc  <= rom_addr_o;
                        state      <= S_WAIT;
                        rom_req_o  <= 1'b0;
                        rom_addr_o <= 32'h0;
                    end else begin
                        rom_addr_o <= target;
                    end
                end
                S_WAIT: begin
                    if (rom_rvalid_i) begin
                        drop       <= 1'b0;
                        state      <= S_REQ;
                        rom_req_o  <= 1'b1;
                        rom_addr_o <= target;
                    end else begin
                        drop <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_after;
            case (state)
                S_IDLE: begin
                    if (issue_ok) begin
                        state      <= S_REQ;
                        rom_req_o  <= 1'b1;
                        rom_addr_o <= fetch_pc;
                    end
                end
                S_REQ: begin
                    if (rom_gnt_i) begin
                        fetch_pc   <= fetch_pc + 32'd4;
                        issued_pc  <= rom_addr_o;
                        state      <= S_WAIT;
                        rom_req_o  <= 1'b0;
                        rom_addr_o <= 32'h0;
                    end
                end
                S_WAIT: begin
                    if (rom_rvalid_i) begin
                        drop <= 1'b0;
                        if (issue_ok) begin
                            state      <= S_REQ;
                            rom_req_o  <= 1'b1;
                            rom_addr_o <= fetch_pc;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Purpose  : Directed self-checking bench for if_fetch with a simple ROM model.
// Revision : 1.0
// ============================================================================
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt_i;
    logic        rom_rvalid_i;
    logic [31:0] rom_rdata_i;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    int checks   = 0;
    int failures = 0;

    logic        gnt_en;
    logic        slow;
    logic        s1_v, s2_v;
    logic [31:0] s1_a, s2_a;
    logic [31:0] seen [$];

    if_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .rom_req_o      (rom_req_o),
        .rom_addr_o     (rom_addr_o),
        .rom_gnt_i      (rom_gnt_i),
        .rom_rvalid_i   (rom_rvalid_i),
        .rom_rdata_i    (rom_rdata_i),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_valid       (if_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    // ROM: grant when enabled, respond one (or, when slow, two) cycles after grant.
    assign rom_gnt_i    = rom_req_o & gnt_en;
    assign rom_rvalid_i = slow ? s2_v : s1_v;
    assign rom_rdata_i  = inst_of(slow ? s2_a : s1_a);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s1_a <= 32'h0;
            s2_a <= 32'h0;
        end else begin
            s1_v <= rom_req_o & rom_gnt_i;
            s1_a <= rom_addr_o;
            s2_v <= s1_v;
            s2_a <= s1_a;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && if_valid && !stall_i) begin
            seen.push_back(if_pc);
            check_val("inst", {32'h0, if_inst}, {32'h0, inst_of(if_pc)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic slow_mode, input logic gnt_mode, input logic stall_mode);
        rst             = 1'b0;
        stall_i         = stall_mode;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
        gnt_en          = gnt_mode;
        slow            = slow_mode;
        @(posedge clk);
        #1;
        rst = 1'b1;
        seen.delete();
    endtask

    task automatic wait_req(input string tag, input logic [31:0] a);
        int n = 0;
        tick();
        while (!(rom_req_o && rom_addr_o == a) && n < 30) begin
            tick();
            n++;
        end
        check_val(tag, {31'h0, rom_req_o, rom_addr_o}, {31'h0, 1'b1, a});
    endtask

    task automatic wait_seen(input string tag, input int n);
        int k = 0;
        while (seen.size() < n && k < 40) begin
            tick();
            k++;
        end
        check_val(tag, 64'(seen.size()), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: reset state, latency and one-per-two-cycle streaming
        rst = 1'b0;
        stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'h0;
        gnt_en = 1'b1; slow = 1'b0;
        #3;
        check_val("rst_outs", {rom_req_o, rom_addr_o, if_valid, if_pc, if_inst[29:0]}, 64'h0);
        do_reset(1'b0, 1'b1, 1'b0);
        tick();
        check_val("t1_req0", {31'h0, rom_req_o, rom_addr_o}, {31'h0, 1'b1, 32'h0});
        tick();
        check_val("t1_lat_n1", {63'h0, if_valid}, 64'h0);
        tick();
        check_val("t1_first", {31'h0, if_valid, if_pc}, {31'h0, 1'b1, 32'h0});
        tick();
        check_val("t1_gap", {63'h0, if_valid}, 64'h0);
        tick();
        check_val("t1_second", {31'h0, if_valid, if_pc}, {31'h0, 1'b1, 32'h4});
        wait_seen("t1_cnt", 4);
        check_val("t1_seq2", {32'h0, seen[2]}, 64'h8);
        check_val("t1_seq3", {32'h0, seen[3]}, 64'hC);

        // Test 2: stall fills buffer, release drains in order
        do_reset(1'b0, 1'b1, 1'b1);
        repeat (8) tick();
        check_val("t2_full", {30'h0, rom_req_o, if_valid, if_pc}, {30'h0, 1'b0, 1'b1, 32'h0});
        stall_i = 1'b0;
        wait_seen("t2_cnt", 3);
        check_val("t2_s0", {32'h0, seen[0]}, 64'h0);
        check_val("t2_s1", {32'h0, seen[1]}, 64'h4);
        check_val("t2_s2", {32'h0, seen[2]}, 64'h8);

        // Test 3: branch while waiting on pc 0x8 (slow ROM)
        do_reset(1'b1, 1'b1, 1'b0);
        wait_req("t3_req8", 32'h8);
        tick();
        branch_flag_i = 1'b1; branch_target_i = 32'h100;
        seen.delete();
        tick();
        branch_flag_i = 1'b0;
        check_val("t3_clear", {63'h0, if_valid}, 64'h0);
        tick();
        check_val("t3_retry", {31'h0, rom_req_o, rom_addr_o}, {31'h0, 1'b1, 32'h100});
        wait_seen("t3_cnt", 1);
        check_val("t3_pc", {32'h0, seen[0]}, 64'h100);

        // Test 4: retarget an ungranted request
        do_reset(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_val("t4_hold", {31'h0, rom_req_o, rom_addr_o}, {31'h0, 1'b1, 32'h0});
        branch_flag_i = 1'b1; branch_target_i = 32'h203;
        tick();
        branch_flag_i = 1'b0;
        check_val("t4_addr", {31'h0, rom_req_o, rom_addr_o}, {31'h0, 1'b1, 32'h200});
        gnt_en = 1'b1;
        wait_seen("t4_cnt", 1);
        check_val("t4_pc", {32'h0, seen[0]}, 64'h200);

        // Test 5: branch coinciding with rvalid, then a second branch while granted
        do_reset(1'b0, 1'b1, 1'b0);
        tick();
        tick();
        seen.delete();
        branch_flag_i = 1'b1; branch_target_i = 32'h80;
        tick();
        check_val("t5_req80", {31'h0, rom_req_o, rom_addr_o}, {31'h0, 1'b1, 32'h80});
        branch_target_i = 32'h40;
        tick();
        branch_flag_i = 1'b0;
        check_val("t5_idle", {62'h0, rom_req_o, if_valid}, 64'h0);
        wait_seen("t5_cnt", 2);
        check_val("t5_s0", {32'h0, seen[0]}, 64'h40);
        check_val("t5_s1", {32'h0, seen[1]}, 64'h44);

        // Test 6: PC wrap and asynchronous reset mid-WAIT
        do_reset(1'b0, 1'b1, 1'b1);
        tick();
        branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
        tick();
        branch_flag_i = 1'b0;
        wait_req("t6_top", 32'hFFFF_FFFC);
        wait_req("t6_wrap", 32'h0);
        check_val("t6_head", {if_pc, if_inst}, {32'hFFFF_FFFC, inst_of(32'hFFFF_FFFC)});
        tick();
        #2;
        rst = 1'b0;
        #1;
        check_val("t6_arst", {rom_req_o, rom_addr_o, if_valid, if_pc, if_inst[29:0]}, 64'h0);
        stall_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        seen.delete();
        wait_seen("t6_cnt", 1);
        check_val("t6_pc", {32'h0, seen[0]}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
